uart_tx_arbiter: RTL

//  Shares the single UART transmit AXI-Stream input among NUM_SRC packet sources.

---
 rtl/uart_tx_arbiter.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
//
// Shares one UART transmit AXI-Stream input among NUM_SRC packet sources.
// Sources are served round-robin, one whole packet per grant (no
// interleaving). Every packet is preceded by a header byte
// HDR_BASE | source_index. A grant also ends after MAX_PKT payload beats.
// When that happens, the remainder of the packet is re-arbitrated and gets
// a fresh header.
//
// Ports
//   clk            system clock
//   rst            synchronous reset, active high
//   s_axis_tdata   NUM_SRC*DATA_WIDTH, source i at [i*DATA_WIDTH +: DATA_WIDTH]
//   s_axis_tvalid  per-source valid
//   s_axis_tlast   per-source end of packet
//   s_axis_tready  per-source ready, at most one bit high
//   m_axis_tdata   byte to the UART
//   m_axis_tvalid  valid to the UART
//   m_axis_tready  ready from the UART
//   grant_valid    high while a source is granted (header or payload phase)
//   grant_id       index of the granted source
// ---------------------------------------------------------------------------
module uart_tx_arbiter #(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    NUM_SRC    = 4,
    parameter logic [DATA_WIDTH-1:0] HDR_BASE   = 8'hA0,
    parameter int                    MAX_PKT    = 64,
    localparam int                   IDW        = (NUM_SRC > 2) ? $clog2(NUM_SRC) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [NUM_SRC-1:0]            s_axis_tvalid,
    input  logic [NUM_SRC-1:0]            s_axis_tlast,
    output logic [NUM_SRC-1:0]            s_axis_tready,
    output logic [DATA_WIDTH-1:0]         m_axis_tdata,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic                          grant_valid,
    output logic [IDW-1:0]                grant_id
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    localparam logic [IDW:0] NUM_SRC_W = (IDW + 1)'(NUM_SRC);
    localparam logic [15:0]  MAX_PKT_W = 16'(MAX_PKT);

    state_t                  state_q;
    logic [IDW-1:0]          grant_id_q;
    logic [IDW-1:0]          last_grant_q;
    logic [15:0]             beat_cnt_q;
    logic [15:0]             beat_cnt_d;
    logic [DATA_WIDTH-1:0]   hdr_q;

    logic [DATA_WIDTH-1:0]   src_data [NUM_SRC];
    logic                    cur_valid;
    logic                    cur_last;
    logic [DATA_WIDTH-1:0]   cur_data;
    logic                    beat_fire;
    logic                    pkt_end;

    logic                    pick_found;
    logic [IDW-1:0]          pick_id;

    // Per-source data slicing and ready steering: only the granted source
    // sees the UART ready, and only during the payload phase.
    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
            assign src_data[gi]      = s_axis_tdata[gi*DATA_WIDTH +: DATA_WIDTH];
            assign s_axis_tready[gi] = (state_q == ST_DATA) &&
                                       (grant_id_q == IDW'(gi)) &&
                                       m_axis_tready;
        end
    endgenerate

    // Round-robin pick: first requester scanning upward from last_grant+1.
    // The sum is one bit wider than an index so the wrap is a single subtract.
    always_comb begin
        logic [IDW:0] idx;
        pick_found = 1'b0;
        pick_id    = '0;
        idx        = '0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            idx = {1'b0, last_grant_q} + (IDW + 1)'(k);
            if (idx >= NUM_SRC_W) begin
                idx = idx - NUM_SRC_W;
            end
            if (!pick_found && s_axis_tvalid[idx[IDW-1:0]]) begin
                pick_found = 1'b1;
                pick_id    = idx[IDW-1:0];
            end
        end
    end

    assign cur_valid  = s_axis_tvalid[grant_id_q];
    assign cur_last   = s_axis_tlast[grant_id_q];
    assign cur_data   = src_data[grant_id_q];
    assign beat_fire  = (state_q == ST_DATA) && cur_valid && m_axis_tready;
    assign beat_cnt_d = beat_cnt_q + 16'd1;
    // Packet ends on tlast or on the MAX_PKT-th beat of this grant.
    assign pkt_end    = cur_last || (beat_cnt_d == MAX_PKT_W);

    // Header phase drives the registered header byte; payload phase is a
    // straight pass-through, so m_axis_tvalid never depends on m_axis_tready.
    assign m_axis_tvalid = (state_q == ST_HDR) || ((state_q == ST_DATA) && cur_valid);
    assign m_axis_tdata  = (state_q == ST_DATA) ? cur_data : hdr_q;
    assign grant_valid   = (state_q == ST_HDR) || (state_q == ST_DATA);
    assign grant_id      = grant_id_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            grant_id_q   <= '0;
            last_grant_q <= IDW'(NUM_SRC - 1);
            beat_cnt_q   <= '0;
            hdr_q        <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pick_found) begin
                        grant_id_q <= pick_id;
                        hdr_q      <= HDR_BASE | DATA_WIDTH'(pick_id);
                        state_q    <= ST_HDR;
                    end
                end
                ST_HDR: begin
                    if (m_axis_tready) begin
                        beat_cnt_q <= '0;
                        state_q    <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (beat_fire) begin
                        beat_cnt_q <= beat_cnt_d;
                        if (pkt_end) begin
                            last_grant_q <= grant_id_q;
                            state_q      <= ST_IDLE;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule
